// File: rtl/half_image_loader.sv
// Input stage of the half-precision inference pipeline: converts a streamed 8-bit image to
// half-precision pixel/255, holds it for layer 1 and pulses start once the frame is complete.
module half_image_loader #(
    parameter int unsigned LAYER1_NEURONS = 784,
    parameter int unsigned COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    input  logic               pix_last,
    output logic               pix_ready,
    output logic [15:0]        x [LAYER1_NEURONS],
    output logic               start,
    input  logic               done,
    output logic               busy,
    output logic               frame_err,
    output logic [COUNT_W-1:0] image_count
);

    localparam int unsigned IdxW = (LAYER1_NEURONS > 1) ? $clog2(LAYER1_NEURONS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(LAYER1_NEURONS - 1);

    typedef enum logic [1:0] {
        StFill,
        StStart,
        StWaitDone
    } state_e;

    // Exact p/255 in half precision. Ties cannot occur because 255 is odd, so rounding the
    // remainder up past the midpoint is already round-to-nearest-even.
    function automatic logic [15:0] pix_to_half(input int unsigned p);
        int unsigned k;
        int unsigned num;
        int unsigned q;
        int unsigned r;
        logic [4:0]  expo;
        if (p == 0) begin
            return 16'h0000;
        end
        // Smallest k with p * 2^k >= 255, i.e. p/255 lies in [2^-k, 2^(1-k)).
        k = 8;
        for (int i = 8; i >= 0; i--) begin
            if ((p << i) >= 255) begin
                k = i;
            end
        end
        num  = p << (10 + k);
        q    = num / 255;
        r    = num % 255;
        expo = 5'(15 - k);
        if (2 * r > 255) begin
            q = q + 1;
        end
        if (q == 2048) begin
            q    = 1024;
            expo = expo + 5'd1;
        end
        return {1'b0, expo, q[9:0]};
    endfunction

    logic [15:0] half_lut [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_lut
        assign half_lut[gi] = pix_to_half(gi);
    end

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            frame_err_d;
    logic            accept;
    logic            at_last;

    // pix_ready is only ever high in FILL, so accept needs no extra state qualification.
    assign accept  = pix_valid & pix_ready;
    assign at_last = (idx_q == LastIdx);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_err_d = frame_err;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    if (at_last && pix_last) begin
                        idx_d   = '0;
                        state_d = StStart;
                    end else if (at_last || pix_last) begin
                        // Misframed image: drop it and resynchronise on the next pixel.
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (done) begin
                    state_d = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StFill;
            idx_q       <= '0;
            pix_ready   <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            image_count <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_ready   <= (state_d == StFill);
            start       <= (state_d == StStart);
            busy        <= (state_d != StFill);
            frame_err   <= frame_err_d;
            if (state_q == StStart) begin
                image_count <= image_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LAYER1_NEURONS; i++) begin
                x[i] <= 16'h0000;
            end
        end else if (accept) begin
            x[idx_q] <= half_lut[pix_data];
        end
    end

endmodule

// File: tb/tb_half_image_loader.sv
// Directed self-checking bench for half_image_loader: conversion, framing, handshake,
// stray done, mid-frame reset and image counter wrap (COUNT_W = 2).
module tb_half_image_loader;

    localparam int unsigned N  = 784;
    localparam int unsigned CW = 2;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_data  = 8'h00;
    logic          pix_last  = 1'b0;
    logic          done      = 1'b0;
    logic          pix_ready;
    logic          start;
    logic          busy;
    logic          frame_err;
    logic [15:0]   x [N];
    logic [CW-1:0] image_count;

    logic [15:0]   exp_x [N];
    int            n_assert  = 0;
    int            n_fail    = 0;
    int            start_cnt = 0;

    half_image_loader #(
        .LAYER1_NEURONS(N),
        .COUNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .x          (x),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .frame_err  (frame_err),
        .image_count(image_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference conversion in floating point, rounding to nearest even.
    function automatic logic [15:0] real_to_half(input real v);
        int  e;
        int  m;
        real f;
        real fr;
        if (v == 0.0) return 16'h0000;
        e = 0;
        while (v < 1.0) begin
            v = v * 2.0;
            e--;
        end
        f  = (v - 1.0) * 1024.0;
        m  = int'($floor(f));
        fr = f - real'(m);
        if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m++;
        if (m == 1024) begin
            m = 0;
            e++;
        end
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    // 0: cyclic sweep 0..255; 1: digit-like blob on a 28x28 grid; other: scrambled values.
    function automatic logic [7:0] pix_of(input int pat, input int k);
        int r;
        int c;
        r = k / 28;
        c = k % 28;
        case (pat)
            0: return 8'(k % 256);
            1: return (r >= 6 && r <= 21 && c >= 9 && c <= 18) ?
                      8'((r * 13 + c * 7) % 128 + 128) : 8'h00;
            default: return 8'((k * 37 + 11) % 256);
        endcase
    endfunction

    task automatic check_x(input string tag);
        for (int k = 0; k < N; k++) begin
            chk(tag, x[k], exp_x[k]);
        end
    endtask

    // Sends pixels 0..n-1 of a pattern; returns just after the edge accepting the last one.
    task automatic send_frame(input int pat, input int n, input int last_at, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int         guard;
            logic [7:0] d;
            d = pix_of(pat, k);
            @(negedge clk);
            pix_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = d;
            pix_last  = (k == last_at);
            guard     = 0;
            while (pix_ready !== 1'b1 && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            chk("pix_accept", pix_ready, 1);
            exp_x[k] = real_to_half(real'(d) / 255.0);
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            pix_last  = 1'b0;
        end
    endtask

    task automatic after_frame(input int sc0, input logic [CW-1:0] cnt_before);
        logic [CW-1:0] nxt;
        nxt = cnt_before + 1'b1;
        chk("start_high", start, 1);
        chk("busy_in_start", busy, 1);
        chk("ready_in_start", pix_ready, 0);
        chk("count_before_inc", image_count, cnt_before);
        @(posedge clk);
        #1;
        chk("start_low", start, 0);
        chk("busy_in_wait", busy, 1);
        chk("count_inc", image_count, nxt);
        chk("start_once", start_cnt, sc0 + 1);
    endtask

    // Drives junk pixels while layer 1 "computes", then answers with done.
    task automatic wait_done(input int cycles);
        pix_valid = 1'b1;
        pix_data  = 8'hAA;
        pix_last  = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("ready_in_wait", pix_ready, 0);
            chk("busy_in_wait", busy, 1);
        end
        check_x("x_frozen");
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done      = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        chk("ready_after_done", pix_ready, 1);
        chk("busy_after_done", busy, 0);
        check_x("x_after_done");
    endtask

    initial begin
        int sc;
        for (int k = 0; k < N; k++) exp_x[k] = 16'h0000;

        // Reset values
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", pix_ready, 0);
        chk("reset_start", start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_count", image_count, 0);
        check_x("x_reset");
        rstn = 1'b1;
        #1;
        chk("ready_at_release", pix_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", pix_ready, 1);

        // Conversion sweep, back-to-back
        sc = start_cnt;
        send_frame(0, N, N - 1, 0);
        after_frame(sc, 2'd0);
        check_x("x_sweep");
        chk("spot_0", x[0], 16'h0000);
        chk("spot_1", x[1], 16'h1C04);
        chk("spot_128", x[128], 16'h3804);
        chk("spot_255", x[255], 16'h3C00);
        chk("spot_256", x[256], 16'h0000);
        wait_done(20);

        // Digit-like frame, valid held high
        sc = start_cnt;
        send_frame(1, N, N - 1, 0);
        after_frame(sc, 2'd1);
        check_x("x_digit");
        wait_done(20);

        // Stray done while filling
        sc = start_cnt;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("stray_done_busy", busy, 0);
        chk("stray_done_ready", pix_ready, 1);
        chk("stray_done_start", start_cnt, sc);
        chk("stray_done_count", image_count, 2);

        // Same frame with random bubbles
        send_frame(1, N, N - 1, 3);
        after_frame(sc, 2'd2);
        check_x("x_bubbles");
        wait_done(5);

        // Early pix_last at index 100
        sc = start_cnt;
        send_frame(2, 101, 100, 0);
        chk("err100_flag", frame_err, 1);
        chk("err100_ready", pix_ready, 1);
        chk("err100_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("err100_no_start", start_cnt, sc);
        check_x("x_partial");

        // Next good frame resynchronises; counter wraps 3 -> 0
        send_frame(0, N, N - 1, 0);
        after_frame(sc, 2'd3);
        chk("count_wrap", image_count, 0);
        check_x("x_after_err100");
        wait_done(3);

        // Reset at pixel 400
        send_frame(2, 400, -1, 0);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < N; k++) exp_x[k] = 16'h0000;
        check_x("x_midreset");
        chk("midreset_start", start, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_ready", pix_ready, 0);
        chk("midreset_frame_err", frame_err, 0);
        chk("midreset_count", image_count, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        sc = start_cnt;
        send_frame(2, N, N - 1, 0);
        after_frame(sc, 2'd0);
        check_x("x_after_reset");
        chk("after_reset_frame_err", frame_err, 0);
        wait_done(3);

        // Missing pix_last at the final index
        sc = start_cnt;
        send_frame(1, N, -1, 0);
        chk("nolast_flag", frame_err, 1);
        chk("nolast_ready", pix_ready, 1);
        chk("nolast_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("nolast_no_start", start_cnt, sc);
        check_x("x_nolast");

        send_frame(0, N, N - 1, 0);
        after_frame(sc, 2'd1);
        check_x("x_after_nolast");
        wait_done(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
